stage0_decode: RTL and testbench

//  Decode/register-read stage feeding the execute stage (stage1). Accepts 32-bit instructions

---
 rtl/stage_pkg.sv | 72 +++++++
 rtl/stage0_decode_if.sv | 30 +++
 rtl/stage0_decode_regfile.sv | 37 +++
 rtl/stage0_decode.sv | 97 +++++++++
 tb/tb_stage0_decode.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/stage_pkg.sv
// Shared types and encodings for the decode/register-read stage: opcodes,
// control_in fields, the execute bundle and the opcode decode table.
package stage_pkg;

   localparam int NREGS  = 32;
   localparam int DATA_W = 32;
   localparam int AW     = $clog2(NREGS);

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h03;
   localparam logic [5:0] OP_AND  = 6'h04;
   localparam logic [5:0] OP_SLL  = 6'h08;
   localparam logic [5:0] OP_SLLI = 6'h09;
   localparam logic [5:0] OP_SRL  = 6'h0A;
   localparam logic [5:0] OP_SRLI = 6'h0B;
   localparam logic [5:0] OP_LW   = 6'h10;
   localparam logic [5:0] OP_SW   = 6'h11;

   localparam logic [2:0] OPSEL_SHIFT  = 3'b000;
   localparam logic [2:0] OPSEL_ARITH  = 3'b001;
   localparam logic [2:0] OPSEL_MEM_WR = 3'b100;
   localparam logic [2:0] OPSEL_MEM_RD = 3'b101;

   localparam logic [2:0] OPER_ADD = 3'b000;
   localparam logic [2:0] OPER_SUB = 3'b001;
   localparam logic [2:0] OPER_AND = 3'b010;
   localparam logic [2:0] OPER_SLL = 3'b000;
   localparam logic [2:0] OPER_SRL = 3'b001;

   typedef struct packed {
      logic [DATA_W-1:0] src1;
      logic [DATA_W-1:0] src2;
      logic [DATA_W-1:0] imm;
      logic [6:0]        control_in;
      logic [AW-1:0]     dest_addr;
      logic              enable_ex;
   } ex_bundle_t;

   typedef struct packed {
      logic       legal;
      logic       issue;
      logic       writes_rd;
      logic [6:0] control;
   } dec_t;

   // control = {operation, immediate select, opselect}
   function automatic dec_t decode_op(input logic [5:0] opcode);
      dec_t d;
      d.legal     = 1'b1;
      d.issue     = 1'b1;
      d.writes_rd = 1'b1;
      d.control   = 7'd0;
      case (opcode)
         OP_NOP:  begin d.issue = 1'b0; d.writes_rd = 1'b0; end
         OP_ADD:  d.control = {OPER_ADD, 1'b0, OPSEL_ARITH};
         OP_SUB:  d.control = {OPER_SUB, 1'b0, OPSEL_ARITH};
         OP_ADDI: d.control = {OPER_ADD, 1'b1, OPSEL_ARITH};
         OP_AND:  d.control = {OPER_AND, 1'b0, OPSEL_ARITH};
         OP_SLL:  d.control = {OPER_SLL, 1'b0, OPSEL_SHIFT};
         OP_SLLI: d.control = {OPER_SLL, 1'b1, OPSEL_SHIFT};
         OP_SRL:  d.control = {OPER_SRL, 1'b0, OPSEL_SHIFT};
         OP_SRLI: d.control = {OPER_SRL, 1'b1, OPSEL_SHIFT};
         OP_LW:   d.control = {OPER_ADD, 1'b1, OPSEL_MEM_RD};
         OP_SW:   begin d.control = {OPER_ADD, 1'b1, OPSEL_MEM_WR}; d.writes_rd = 1'b0; end
         default: begin d.legal = 1'b0; d.issue = 1'b0; d.writes_rd = 1'b0; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/stage0_decode_if.sv
// Fetch-side handshake and execute-side bundle of the decode stage.
interface stage0_decode_if
   import stage_pkg::*;
   ();

   // Fetch handshake: instr_in transfers on a rising edge where instr_valid
   // and instr_ready are both 1; instr_ready never depends on instr_valid.
   logic [31:0]       instr_in;
   logic              instr_valid;
   logic              instr_ready;
   logic              stall_in;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic [DATA_W-1:0] imm;
   logic [6:0]        control_in;
   logic [AW-1:0]     dest_addr;
   logic              enable_ex;
   logic              illegal_instr;

   modport master (
      output instr_in, instr_valid, stall_in,
      input  instr_ready, src1, src2, imm, control_in, dest_addr, enable_ex, illegal_instr
   );

   modport slave (
      input  instr_in, instr_valid, stall_in,
      output instr_ready, src1, src2, imm, control_in, dest_addr, enable_ex, illegal_instr
   );

endinterface

// File: rtl/stage0_decode_regfile.sv
// Register file: two combinational read ports with write-through bypass,
// one write port, r0 hard-wired to zero, asynchronous clear.
module regfile
   import stage_pkg::*;
   (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr1,
   input  logic [AW-1:0]     rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // r0 check comes first so a write aimed at r0 can never bypass into a read
   always_comb begin
      rd_data1 = mem[rd_addr1];
      if (rd_addr1 == '0)                        rd_data1 = '0;
      else if (wr_en && wr_addr == rd_addr1)     rd_data1 = wr_data;
      rd_data2 = mem[rd_addr2];
      if (rd_addr2 == '0)                        rd_data2 = '0;
      else if (wr_en && wr_addr == rd_addr2)     rd_data2 = wr_data;
   end

endmodule

// File: rtl/stage0_decode.sv
// Decode/register-read stage: decodes instr_in, reads the register file and
// registers the execute bundle. Optional load-use interlock: HAZARD_DETECT_EN.
module stage0_decode
   import stage_pkg::*;
   (
   input  logic              CLOCK,
   input  logic              RESET_N,
   stage0_decode_if.slave    bus,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [5:0]        opcode;
   logic [AW-1:0]     rd;
   logic [AW-1:0]     rs1;
   logic [AW-1:0]     rs2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              interlock;
   logic              transfer;
   dec_t              dec;
   ex_bundle_t        ex_q;
   ex_bundle_t        ex_d;
   logic              illegal_q;
   logic              illegal_d;

   assign opcode = bus.instr_in[31:26];
   assign rd     = bus.instr_in[25:21];
   assign rs1    = bus.instr_in[20:16];
   assign rs2    = bus.instr_in[15:11];
   assign dec    = decode_op(opcode);

   regfile u_regfile (
      .clk      (CLOCK),
      .rst_n    (RESET_N),
      .wr_en    (wb_en),
      .wr_addr  (wb_addr),
      .wr_data  (wb_data),
      .rd_addr1 (rs1),
      .rd_addr2 (rs2),
      .rd_data1 (rdata1),
      .rd_data2 (rdata2)
   );

`ifdef HAZARD_DETECT_EN
   // The bubble issued by the interlock clears its own trigger, so it lasts one cycle
   assign interlock = ex_q.enable_ex && (ex_q.control_in[2:0] == OPSEL_MEM_RD) &&
                      ((rs1 != '0 && rs1 == ex_q.dest_addr) ||
                       (rs2 != '0 && rs2 == ex_q.dest_addr));
`else
   assign interlock = 1'b0;
`endif

   assign bus.instr_ready = RESET_N & ~bus.stall_in & ~interlock;
   assign transfer        = bus.instr_valid & bus.instr_ready;

   always_comb begin
      ex_d      = ex_q;
      illegal_d = 1'b0;
      if (!bus.stall_in) begin
         ex_d.enable_ex  = 1'b0;
         ex_d.control_in = '0;
         ex_d.dest_addr  = '0;
         if (transfer) begin
            ex_d.src1 = rdata1;
            ex_d.src2 = rdata2;
            ex_d.imm  = {{(DATA_W-16){bus.instr_in[15]}}, bus.instr_in[15:0]};
            if (dec.issue) begin
               ex_d.enable_ex  = 1'b1;
               ex_d.control_in = dec.control;
               ex_d.dest_addr  = dec.writes_rd ? rd : '0;
            end
            illegal_d = ~dec.legal;
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ex_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.src1          = ex_q.src1;
   assign bus.src2          = ex_q.src2;
   assign bus.imm           = ex_q.imm;
   assign bus.control_in    = ex_q.control_in;
   assign bus.dest_addr     = ex_q.dest_addr;
   assign bus.enable_ex     = ex_q.enable_ex;
   assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_stage0_decode.sv
// Directed bench for stage0_decode; define HAZARD_DETECT_EN to test the interlock build.
module tb_stage0_decode;
   import stage_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              wb_en;
   logic [4:0]        wb_addr;
   logic [31:0]       wb_data;
   int                checks;
   int                failures;

   stage0_decode_if bus ();

   stage0_decode dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .bus     (bus),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   // clock / reset / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [5:0] tbl_op   [11] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08,
                                 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11};
   logic [6:0] tbl_ctrl [11] = '{7'b0000000, 7'b0000001, 7'b0010001, 7'b0001001,
                                 7'b0100001, 7'b0000000, 7'b0001000, 7'b0010000,
                                 7'b0011000, 7'b0001101, 7'b0001100};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_bundle(input string tag, input logic en, input logic [6:0] ctrl,
                               input logic [4:0] dest);
      check_eq({tag, ".enable_ex"}, {31'd0, bus.enable_ex}, {31'd0, en});
      check_eq({tag, ".control_in"}, {25'd0, bus.control_in}, {25'd0, ctrl});
      check_eq({tag, ".dest_addr"}, {27'd0, bus.dest_addr}, {27'd0, dest});
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins);
      bus.instr_in    = ins;
      bus.instr_valid = 1'b1;
   endtask

   task automatic idle();
      bus.instr_valid = 1'b0;
      bus.instr_in    = 32'd0;
   endtask

   task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
      wb_en   = en;
      wb_addr = addr;
      wb_data = data;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.stall_in = 1'b0;
      idle();
      wb(1'b0, 5'd0, 32'd0);
      bus.instr_valid = 1'b1;
      tick();
      tick();
      #1;
      check_eq("reset.instr_ready", {31'd0, bus.instr_ready}, 32'd0);
      check_bundle("reset", 1'b0, 7'd0, 5'd0);
      idle();
      rst_n = 1'b1;
      tick();

      // ADDI after writeback of r3
      wb(1'b1, 5'd3, 32'h0000_0010);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      drive({6'h03, 5'd4, 5'd3, 16'hFFF0});
      #1;
      check_eq("addi.instr_ready", {31'd0, bus.instr_ready}, 32'd1);
      tick();
      idle();
      check_eq("addi.src1", bus.src1, 32'h0000_0010);
      check_eq("addi.imm", bus.imm, 32'hFFFF_FFF0);
      check_bundle("addi", 1'b1, 7'b0001001, 5'd4);
      tick();
      check_bundle("bubble", 1'b0, 7'd0, 5'd0);
      check_eq("bubble.src1_hold", bus.src1, 32'h0000_0010);

      // same-cycle bypass, then the written value, then r0 under bypass
      wb(1'b1, 5'd5, 32'hCAFE_0001);
      drive({6'h01, 5'd6, 5'd5, 5'd0, 11'd0});
      tick();
      check_eq("bypass.src1", bus.src1, 32'hCAFE_0001);
      check_bundle("bypass", 1'b1, 7'b0000001, 5'd6);
      wb(1'b0, 5'd0, 32'd0);
      drive({6'h01, 5'd6, 5'd0, 5'd5, 11'd0});
      tick();
      check_eq("written.src2", bus.src2, 32'hCAFE_0001);
      check_eq("written.src1_r0", bus.src1, 32'd0);
      wb(1'b1, 5'd0, 32'hDEAD_BEEF);
      drive({6'h01, 5'd6, 5'd0, 5'd0, 11'd0});
      tick();
      wb(1'b0, 5'd0, 32'd0);
      check_eq("r0_bypass.src1", bus.src1, 32'd0);
      check_eq("r0_bypass.src2", bus.src2, 32'd0);

      // stall holds SLLI; regfile write during stall still lands
      drive({6'h09, 5'd2, 5'd3, 16'h0140});
      tick();
      check_eq("slli.imm", bus.imm, 32'h0000_0140);
      check_bundle("slli", 1'b1, 7'b0001000, 5'd2);
      bus.stall_in = 1'b1;
      drive({6'h01, 5'd8, 5'd9, 5'd3, 11'd0});
      wb(1'b1, 5'd9, 32'h0000_0055);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("stall.instr_ready", {31'd0, bus.instr_ready}, 32'd0);
         tick();
         wb(1'b0, 5'd0, 32'd0);
         check_eq("stall.imm_hold", bus.imm, 32'h0000_0140);
         check_bundle("stall", 1'b1, 7'b0001000, 5'd2);
      end
      bus.stall_in = 1'b0;
      tick();
      idle();
      check_bundle("release", 1'b1, 7'b0000001, 5'd8);
      check_eq("release.src1", bus.src1, 32'h0000_0055);
      check_eq("release.src2", bus.src2, 32'h0000_0010);

      // illegal opcode pulse
      drive({6'h3F, 26'd0});
      tick();
      idle();
      check_eq("illegal.pulse", {31'd0, bus.illegal_instr}, 32'd1);
      check_bundle("illegal", 1'b0, 7'd0, 5'd0);
      tick();
      check_eq("illegal.clear", {31'd0, bus.illegal_instr}, 32'd0);

      // full opcode table, back to back
      for (int i = 0; i < 11; i++) begin
         drive({tbl_op[i], 5'd10, 5'd1, 16'h0000});
         #1;
         check_eq("table.instr_ready", {31'd0, bus.instr_ready}, 32'd1);
         tick();
         check_bundle($sformatf("table_op%02h", tbl_op[i]), tbl_op[i] != 6'h00, tbl_ctrl[i],
                      (tbl_op[i] == 6'h00 || tbl_op[i] == 6'h11) ? 5'd0 : 5'd10);
      end
      idle();
      tick();

      // load-use: LW r7 then ADD rs2=7
      drive({6'h10, 5'd7, 5'd3, 16'h0000});
      tick();
      check_bundle("lw", 1'b1, 7'b0001101, 5'd7);
      drive({6'h01, 5'd11, 5'd0, 5'd7, 11'd0});
      #1;
`ifdef HAZARD_DETECT_EN
      check_eq("hazard.instr_ready", {31'd0, bus.instr_ready}, 32'd0);
      tick();
      check_bundle("hazard.bubble", 1'b0, 7'd0, 5'd0);
      check_eq("hazard.ready_again", {31'd0, bus.instr_ready}, 32'd1);
`else
      check_eq("nohazard.instr_ready", {31'd0, bus.instr_ready}, 32'd1);
`endif
      tick();
      idle();
      check_bundle("load_use.add", 1'b1, 7'b0000001, 5'd11);

      // reset mid-bundle clears outputs and the register file
      drive({6'h03, 5'd4, 5'd3, 16'h0001});
      tick();
      check_bundle("pre_reset", 1'b1, 7'b0001001, 5'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check_bundle("mid_reset", 1'b0, 7'd0, 5'd0);
      check_eq("mid_reset.src1", bus.src1, 32'd0);
      check_eq("mid_reset.imm", bus.imm, 32'd0);
      check_eq("mid_reset.instr_ready", {31'd0, bus.instr_ready}, 32'd0);
      tick();
      rst_n = 1'b1;
      drive({6'h01, 5'd1, 5'd3, 5'd9, 11'd0});
      tick();
      idle();
      check_eq("post_reset.src1", bus.src1, 32'd0);
      check_eq("post_reset.src2", bus.src2, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
